// File: rtl/alu_iter.sv
// alu_iter: handshaked iterative ALU for the EX stage.
//   Single-cycle ops (add/logic/shift/set) and multi-cycle MUL/MULH (shift-add)
//   and DIV/REM (restoring), signed or unsigned. Results and flags are registered.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort back to idle, drops any op
//   in_valid / in_ready   operand handshake (in_ready only while idle)
//   InA, InB, Cin         operands and adder carry-in
//   invA, invB            invert operand before use
//   sign                  signed overflow/compare/MUL/DIV semantics
//   Oper                  opcode
//   out_valid / out_ready result handshake
//   Out, ZF, SF, OF, CF   result and flags
//   DZ                    divide-by-zero (DIV/REM only)
module alu_iter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SH_W  = 4,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             Cin,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    input  logic [OP_W-1:0]  Oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             CF,
    output logic             DZ
);

    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(1);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(2);
    localparam logic [OP_W-1:0] OpAdd2 = OP_W'(3);
    localparam logic [OP_W-1:0] OpRol  = OP_W'(4);
    localparam logic [OP_W-1:0] OpSll  = OP_W'(5);
    localparam logic [OP_W-1:0] OpRor  = OP_W'(6);
    localparam logic [OP_W-1:0] OpSrl  = OP_W'(7);
    localparam logic [OP_W-1:0] OpSeq  = OP_W'(8);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(9);
    localparam logic [OP_W-1:0] OpSle  = OP_W'(10);
    localparam logic [OP_W-1:0] OpSco  = OP_W'(11);
    localparam logic [OP_W-1:0] OpMul  = OP_W'(12);
    localparam logic [OP_W-1:0] OpMulh = OP_W'(13);
    localparam logic [OP_W-1:0] OpDiv  = OP_W'(14);
    localparam logic [OP_W-1:0] OpRem  = OP_W'(15);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               sign_q, sign_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Iteration datapath: {hi, lo} is the product (MUL) or {remainder, quotient} (DIV).
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zf_q, zf_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d, dz_q, dz_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Operand conditioning at accept time.
    logic [WIDTH-1:0]   a_eff, b_eff, a_mag, b_mag;
    logic               a_neg, b_neg, in_multi, in_div;

    always_comb begin
        a_eff    = invA ? ~InA : InA;
        b_eff    = invB ? ~InB : InB;
        a_neg    = sign & a_eff[WIDTH-1];
        b_neg    = sign & b_eff[WIDTH-1];
        a_mag    = a_neg ? -a_eff : a_eff;
        b_mag    = b_neg ? -b_eff : b_eff;
        in_multi = Oper[OP_W-1] & Oper[OP_W-2];
        in_div   = Oper[1];
    end

    // Final result computed from the latched operands / iteration registers.
    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   add_sum;
    logic               add_c, add_z, add_s, add_sov, add_o, slt, sle;
    logic [SH_W-1:0]    sh;
    logic [CNT_W-1:0]   sh_inv;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem;
    logic               div_zero, div_ovf, op_multi;
    logic [WIDTH-1:0]   res_out;
    logic               res_zf, res_sf, res_of, res_cf, res_dz;

    always_comb begin
        add_ext  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        add_sum  = add_ext[WIDTH-1:0];
        add_c    = add_ext[WIDTH];
        add_z    = (add_sum == '0);
        add_s    = add_sum[WIDTH-1];
        add_sov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (add_sum[WIDTH-1] != a_q[WIDTH-1]);
        add_o    = sign_q ? add_sov : add_c;
        slt      = (~add_s & ~add_z & ~add_o) | (add_o & add_s);
        sle      = add_z | (~add_s & ~add_o) | (add_o & add_s);
        sh       = b_q[SH_W-1:0];
        sh_inv   = CntMax - CNT_W'(sh);
        prod     = {hi_q, lo_q};
        prod_s   = neg_q ? -prod : prod;
        quo      = neg_q ? -lo_q : lo_q;
        rem      = rem_neg_q ? -hi_q : hi_q;
        div_zero = (b_q == '0);
        // MIN / -1: magnitude path already yields MIN and 0, only OF needs flagging.
        div_ovf  = sign_q & (a_q == MinVal) & (&b_q);
        op_multi = op_q[OP_W-1] & op_q[OP_W-2];

        case (op_q)
            OpAdd, OpAdd2: res_out = add_sum;
            OpXor:  res_out = a_q ^ b_q;
            OpAnd:  res_out = a_q & b_q;
            OpRol:  res_out = (a_q << sh) | (a_q >> sh_inv);
            OpSll:  res_out = a_q << sh;
            OpRor:  res_out = (a_q >> sh) | (a_q << sh_inv);
            OpSrl:  res_out = a_q >> sh;
            OpSeq:  res_out = {{(WIDTH-1){1'b0}}, add_z};
            OpSlt:  res_out = {{(WIDTH-1){1'b0}}, slt};
            OpSle:  res_out = {{(WIDTH-1){1'b0}}, sle};
            OpSco:  res_out = {{(WIDTH-1){1'b0}}, add_c};
            OpMul:  res_out = prod_s[WIDTH-1:0];
            OpMulh: res_out = prod_s[2*WIDTH-1:WIDTH];
            OpDiv:  res_out = div_zero ? '1 : quo;
            OpRem:  res_out = div_zero ? a_q : rem;
            default: res_out = add_sum;
        endcase

        if (op_multi) begin
            res_zf = (res_out == '0);
            res_sf = res_out[WIDTH-1];
            res_cf = 1'b0;
            if (op_q[1]) begin
                res_of = ~div_zero & div_ovf;
                res_dz = div_zero;
            end else begin
                res_of = sign_q ?
                         (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}}) :
                         (prod_s[2*WIDTH-1:WIDTH] != '0);
                res_dz = 1'b0;
            end
        end else begin
            res_zf = add_z;
            res_sf = add_s;
            res_of = add_o;
            res_cf = add_c;
            res_dz = 1'b0;
        end
    end

    // One iteration step for MUL (shift-add) and DIV (restoring).
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_geq;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_geq   = (div_shift >= {1'b0, mag_q});
        div_diff  = div_shift[WIDTH-1:0] - mag_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_d    = sign_q;
        cin_d     = cin_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        out_d     = out_q;
        zf_d      = zf_q;
        sf_d      = sf_q;
        of_d      = of_q;
        cf_d      = cf_q;
        dz_d      = dz_q;

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d      = Oper;
                        sign_d    = sign;
                        cin_d     = Cin;
                        a_d       = a_eff;
                        b_d       = b_eff;
                        hi_d      = '0;
                        lo_d      = in_div ? a_mag : b_mag;
                        mag_d     = in_div ? b_mag : a_mag;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        state_d   = StBusy;
                        // Single-cycle ops start at the terminal count: one BUSY cycle.
                        cnt_d     = in_multi ? '0 : CntMax;
                    end
                end
                StBusy: begin
                    if (cnt_q == CntMax) begin
                        out_d   = res_out;
                        zf_d    = res_zf;
                        sf_d    = res_sf;
                        of_d    = res_of;
                        cf_d    = res_cf;
                        dz_d    = res_dz;
                        state_d = StDone;
                    end else begin
                        if (op_q[1]) begin
                            hi_d = div_geq ? div_diff : div_shift[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], div_geq};
                        end else begin
                            hi_d = mul_sum[WIDTH:1];
                            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            cin_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_q       <= '0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            cf_q        <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            cin_q       <= cin_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            out_q       <= out_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
            cf_q        <= cf_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;
    assign OF        = of_q;
    assign CF        = cf_q;
    assign DZ        = dz_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter (WIDTH=16). A driver pushes the
// reference-model result of each accepted op; a monitor pops and compares on
// every output handshake, and also checks latency and hold-under-backpressure.
module tb_alu_iter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  InA = '0, InB = '0;
    logic          Cin = 1'b0, invA = 1'b0, invB = 1'b0, sign = 1'b0;
    logic [3:0]    Oper = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Out;
    logic          ZF, SF, OF, CF, DZ;

    alu_iter #(.WIDTH(16), .SH_W(4), .OP_W(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .InA(InA), .InB(InB), .Cin(Cin), .invA(invA), .invB(invB), .sign(sign),
        .Oper(Oper), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
        .ZF(ZF), .SF(SF), .OF(OF), .CF(CF), .DZ(DZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] out;
        logic         zf, sf, of, cf, dz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    bit   rand_ready = 1'b1;
    bit   ready_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    function automatic logic [31:0] bundle(input logic [W-1:0] o, input logic z, s, v, c, d);
        return {11'd0, o, z, s, v, c, d};
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] ia, ib,
                                   input logic c, inva, invb, sg);
        exp_t e;
        logic [W-1:0] a, b, sum, o;
        longint ua, ub, sa, sb, cl, us, ss, p, q, r, t;
        int sh;
        logic zf, sf, of, cf, ovf;
        a  = inva ? ~ia : ia;
        b  = invb ? ~ib : ib;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - 65536 : ua;
        sb = b[W-1] ? ub - 65536 : ub;
        cl = longint'(c);
        e.dz = 1'b0; e.cf = 1'b0; e.of = 1'b0; e.lat = 1; e.acc_cyc = 0;
        o = '0;
        if (op < 4'd12) begin
            us  = ua + ub + cl;
            sum = us[W-1:0];
            cf  = (us > 65535);
            ss  = sa + sb + cl;
            ovf = (ss > 32767) || (ss < -32768);
            zf  = (sum == 0);
            sf  = sum[W-1];
            of  = sg ? ovf : cf;
            sh  = int'(b[3:0]);
            case (op)
                4'd0, 4'd3: o = sum;
                4'd1: o = a ^ b;
                4'd2: o = a & b;
                4'd4: begin t = ((ua << sh) | (ua >> (16 - sh))) & 65535; o = t[W-1:0]; end
                4'd5: begin t = (ua << sh) & 65535; o = t[W-1:0]; end
                4'd6: begin t = ((ua >> sh) | (ua << (16 - sh))) & 65535; o = t[W-1:0]; end
                4'd7: begin t = ua >> sh; o = t[W-1:0]; end
                4'd8: o = {15'd0, zf};
                4'd9: o = {15'd0, (~sf & ~zf & ~of) | (of & sf)};
                4'd10: o = {15'd0, zf | (~sf & ~of) | (of & sf)};
                default: o = {15'd0, cf};
            endcase
            e.zf = zf; e.sf = sf; e.of = of; e.cf = cf;
        end else begin
            e.lat = W + 1;
            if (op < 4'd14) begin
                p = sg ? sa * sb : ua * ub;
                o = (op == 4'd12) ? p[15:0] : p[31:16];
                e.of = sg ? ((p > 32767) || (p < -32768)) : (p > 65535);
            end else if (b == 0) begin
                e.dz = 1'b1;
                o = (op == 4'd14) ? 16'hFFFF : a;
            end else if (sg && sa == -32768 && sb == -1) begin
                o = (op == 4'd14) ? 16'h8000 : 16'h0000;
                e.of = 1'b1;
            end else begin
                q = sg ? sa / sb : ua / ub;
                r = sg ? sa % sb : ua % ub;
                o = (op == 4'd14) ? q[15:0] : r[15:0];
            end
            e.zf = (o == 0);
            e.sf = o[W-1];
        end
        e.out = o;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b,
                         input logic c, ia, ib, sg);
        exp_t e;
        int   n;
        @(negedge clk);
        Oper = op; InA = a; InB = b; Cin = c; invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            e = model(op, a, b, c, ia, ib, sg);
            @(posedge clk);
            #1;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // out_ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: latency, hold-while-stalled and result comparison against the queue.
    initial begin
        bit           prev_valid, prev_ready;
        logic [31:0]  prev_b;
        int           start_cyc;
        exp_t         e;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_b = '0; start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (out_valid && !prev_valid) start_cyc = cyc;
                if (out_valid && prev_valid && !prev_ready)
                    chk("hold", bundle(Out, ZF, SF, OF, CF, DZ), prev_b);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bundle(Out, ZF, SF, OF, CF, DZ),
                            bundle(e.out, e.zf, e.sf, e.of, e.cf, e.dz));
                        chk("latency", start_cyc - e.acc_cyc, e.lat);
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_b     = bundle(Out, ZF, SF, OF, CF, DZ);
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic [3:0]   op;
        bit           seen;
        int           n;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_outputs", bundle(Out, ZF, SF, OF, CF, DZ), 32'd0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Directed vectors.
        issue(4'd0, 16'h7FFF, 16'h0001, 0, 0, 0, 1);   // ADD overflow
        issue(4'd0, 16'h0005, 16'h0005, 1, 0, 1, 0);   // SUB to zero
        issue(4'd9, 16'hFFFF, 16'h0001, 1, 1, 0, 1);   // SLT via B-A
        issue(4'd12, 16'hFFFD, 16'h0007, 0, 0, 0, 1);  // MUL -3*7
        issue(4'd13, 16'h4000, 16'h4000, 0, 0, 0, 1);  // MULH overflow
        issue(4'd14, 16'hFFF9, 16'h0002, 0, 0, 0, 1);  // DIV -7/2
        issue(4'd15, 16'hFFF9, 16'h0002, 0, 0, 0, 1);  // REM -7%2
        issue(4'd14, 16'h1234, 16'h0000, 0, 0, 0, 0);  // DIV by zero
        issue(4'd15, 16'h1234, 16'h0000, 0, 0, 0, 1);  // REM by zero
        issue(4'd14, 16'h8000, 16'hFFFF, 0, 0, 0, 1);  // MIN / -1
        issue(4'd15, 16'h8000, 16'hFFFF, 0, 0, 0, 1);  // MIN % -1
        issue(4'd4, 16'h8001, 16'h0000, 0, 0, 0, 0);   // ROL by 0
        issue(4'd6, 16'h8001, 16'h0004, 0, 0, 0, 0);   // ROR by 4
        issue(4'd12, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);  // unsigned MUL max
        drain();

        // Backpressure: result held, in_ready low, then release.
        rand_ready = 1'b0;
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        issue(4'd0, 16'h1111, 16'h2222, 1, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        ready_force = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        rand_ready = 1'b1;
        drain();

        // Async reset in the middle of a multi-cycle op.
        issue(4'd12, 16'h0123, 16'h0456, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rst_outputs", bundle(Out, ZF, SF, OF, CF, DZ), 32'd0);
        chk("abort_rst_out_valid", out_valid, 0);
        chk("abort_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(4'd14, 16'd1000, 16'd7, 0, 0, 0, 0);
        drain();

        // Flush in the middle of a divide; a simultaneous in_valid is ignored.
        issue(4'd14, 16'h7000, 16'h0003, 0, 0, 0, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", seen, 0);
        // Flush while idle with in_valid high: nothing is accepted.
        flush = 1'b1;
        in_valid = 1'b1;
        Oper = 4'd12;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_noaccept", in_ready, 1);
        issue(4'd15, 16'hFF00, 16'h0007, 0, 0, 0, 1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 160; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'($urandom_range(1, 15));
                2: begin a = 16'h8000; b = 16'hFFFF; end
                default: b = 16'($urandom);
            endcase
            issue(op, a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
